// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic unit arbiter: op codes and output-stage FSM encoding.
package logic_unit_arbiter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise datapath shared by both requesters; zero latency, no flow control.
// Op codes 5-7 are illegal: the result is forced to zero and err is raised.
module logic_op_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters; result 1 cycle after accept.
// Backpressure: a held result blocks new accepts unless res_ready drains it in the same cycle.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_src,
  output logic             res_err,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_src;
  logic             r_res_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_can_accept;
  logic             w_grant;
  logic             w_accept;
  logic [OP_W-1:0]  w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

  assign w_can_accept = (r_state == ST_EMPTY) | res_ready;

  // Contention goes to the requester that did not win the last accept.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept   = ~reset & w_can_accept & (req0_valid | req1_valid);
  assign req0_ready = ~reset & w_can_accept & ~w_grant & req0_valid;
  assign req1_ready = ~reset & w_can_accept &  w_grant & req1_valid;

  assign w_op = w_grant ? req1_op : req0_op;
  assign w_a  = w_grant ? req1_a  : req0_a;
  assign w_b  = w_grant ? req1_b  : req0_b;

  logic_op_unit #(
    .WIDTH(WIDTH)
  ) u_op (
    .a  (w_a),
    .b  (w_b),
    .op (w_op),
    .y  (w_y),
    .err(w_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_res_data   <= '0;
      r_res_src    <= 1'b0;
      r_res_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (r_state == ST_FULL && res_ready) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) r_state <= ST_FULL;
        end
        ST_FULL: begin
          if (res_ready && !w_accept) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_res_data   <= w_y;
        r_res_src    <= w_grant;
        r_res_err    <= w_err;
      end
    end
  end

  assign res_valid = (r_state == ST_FULL);
  assign res_data  = r_res_data;
  assign res_src   = r_res_src;
  assign res_err   = r_res_err;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants and results; a monitor checks outputs.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             src;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [2:0]       req0_op = '0, req1_op = '0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_src, res_err;
  logic [CNT_W-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic armed = 1'b0;
  logic m_full = 1'b0;
  logic m_last = 1'b1;
  logic [CNT_W-1:0] m_count = '0;
  exp_t q[$];

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_err(res_err), .op_count(op_count)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic src, input logic [2:0] op,
                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t r;
    r.src = src;
    r.err = 1'b0;
    case (op)
      3'd0: r.data = a & b;
      3'd1: r.data = a | b;
      3'd2: r.data = a ^ b;
      3'd3: r.data = ~(a & b);
      3'd4: r.data = ~(a | b);
      default: begin r.data = '0; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  // Acceptance model: predicts readys from the handshake rules and pushes expected results.
  always @(negedge clk) begin
    logic can, g, e0, e1;
    if (armed) begin
      can = !m_full || res_ready;
      g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e0  = !reset && can && req0_valid && !g;
      e1  = !reset && can && req1_valid && g;
      chk("req0_ready", int'(req0_ready), int'(e0));
      chk("req1_ready", int'(req1_ready), int'(e1));
      chk("res_valid", int'(res_valid), int'(m_full));
      if (reset) begin
        m_full = 1'b0;
        m_last = 1'b1;
        q.delete();
      end else if (e0 || e1) begin
        q.push_back(g ? ref_op(1'b1, req1_op, req1_a, req1_b)
                      : ref_op(1'b0, req0_op, req0_a, req0_b));
        m_full = 1'b1;
        m_last = g;
      end else if (res_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares any presented result against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      chk("op_count", int'(op_count), int'(m_count));
      if (reset) begin
        m_count = '0;
      end else if (res_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q[0];
          chk("res_data", int'(res_data), int'(e.data));
          chk("res_src", int'(res_src), int'(e.src));
          chk("res_err", int'(res_err), int'(e.err));
          if (res_ready) begin
            void'(q.pop_front());
            m_count = m_count + 1'b1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    // Reset, with a request pending to confirm no ready leaks out.
    reset = 1'b1;
    req0_valid = 1'b1;
    cyc();
    armed = 1'b1;
    #1 chk("rst_ready0", int'(req0_ready), 0);
    cyc();
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_src", int'(res_src), 0);
    chk("rst_res_err", int'(res_err), 0);
    chk("rst_op_count", int'(op_count), 0);
    req0_valid = 1'b0;
    reset = 1'b0;

    // Single AND.
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'hC; req0_b = 4'hA;
    #1 chk("single_ready", int'(req0_ready), 1);
    cyc();
    req0_valid = 1'b0;
    chk("single_data", int'(res_data), 8);
    cyc();
    chk("single_count", int'(op_count), 1);

    // Contention alternates starting from requester 0.
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 4'hF; req0_b = 4'h0;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 4'h5; req1_b = 4'h3;
    for (int i = 0; i < 4; i++) begin
      #1 chk("contend_g0", int'(req0_ready), int'(i % 2 == 0));
      chk("contend_g1", int'(req1_ready), int'(i % 2 == 1));
      cyc();
      chk("contend_data", int'(res_data), (i % 2 == 0) ? 'hF : 'h6);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();

    // Backpressure: result held, then drain and accept together.
    do_reset();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 4'h3; req0_b = 4'h0;
    cyc();
    req0_a = 4'h9;
    #1 chk("bp_blocked", int'(req0_ready), 0);
    cyc();
    chk("bp_held", int'(res_data), 3);
    res_ready = 1'b1;
    #1 chk("bp_b2b_ready", int'(req0_ready), 1);
    cyc();
    req0_valid = 1'b0;
    chk("bp_next", int'(res_data), 9);
    cyc();

    // Illegal op from requester 1.
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 4'hF; req1_b = 4'hF;
    cyc();
    req1_valid = 1'b0;
    chk("ill_data", int'(res_data), 0);
    chk("ill_err", int'(res_err), 1);
    chk("ill_src", int'(res_src), 1);
    cyc();

    // NAND / NOR.
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 4'hC; req0_b = 4'hA;
    cyc();
    req0_op = 3'd4;
    chk("nand", int'(res_data), 7);
    cyc();
    req0_valid = 1'b0;
    chk("nor", int'(res_data), 1);
    cyc();

    // Counter wrap with a 2-bit counter.
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("wrap_count", int'(op_count), (i + 1) % 4);
    end

    // Reset while a result is held.
    res_ready = 1'b0;
    req0_valid = 1'b0;
    #1 chk("full_before_rst", int'(res_valid), 1);
    reset = 1'b1;
    cyc();
    chk("rst_full_drop", int'(res_valid), 0);
    reset = 1'b0;
    cyc();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
